phy_csr_tl_host: RTL and testbench

// - Single-outstanding TL-UL host that drives the PHY CSR TL-UL device port (phy_wrapper) from a simple req/gnt/rvalid register-access interface.
// - Sits directly upstream of the PHY CSR slave: converts word reads/writes into Get/PutFullData/PutPartialData and returns read data and error status.
// - Used by the SoC-side bridge and by Verilator benches that need a flat, cycle-simple CSR master.

---
 rtl/tlul_pkg.sv | 59 +++++
 rtl/phy_csr_tl_host.sv | 169 ++++++++++++++++
 tb/tb_phy_csr_tl_host.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlul_pkg
// Brief    : TL-UL widths, opcodes and channel structs shared by the PHY CSR
//            host and its device port.
// Revision : 1.0 - initial release
// ============================================================================
package tlul_pkg;

   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_AUW = 16;
   localparam int TL_DUW = 4;
   localparam int TL_DBW = TL_DW / 8;
   localparam int TL_SZW = 2;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   localparam logic [TL_AUW-1:0] TL_A_USER_DEFAULT = '0;

   typedef struct packed {
      logic                a_valid;
      tl_a_op_e            a_opcode;
      logic [2:0]          a_param;
      logic [TL_SZW-1:0]   a_size;
      logic [TL_AIW-1:0]   a_source;
      logic [TL_AW-1:0]    a_address;
      logic [TL_DBW-1:0]   a_mask;
      logic [TL_DW-1:0]    a_data;
      logic [TL_AUW-1:0]   a_user;
      logic                d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic                d_valid;
      tl_d_op_e            d_opcode;
      logic [2:0]          d_param;
      logic [TL_SZW-1:0]   d_size;
      logic [TL_AIW-1:0]   d_source;
      logic [TL_DIW-1:0]   d_sink;
      logic [TL_DW-1:0]    d_data;
      logic [TL_DUW-1:0]   d_user;
      logic                d_error;
      logic                a_ready;
   } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/phy_csr_tl_host.sv
`default_nettype none
// ============================================================================
// Module   : phy_csr_tl_host
// Brief    : Single-outstanding TL-UL host turning req/gnt/rvalid word
//            accesses into Get/PutFullData/PutPartialData for the PHY CSR
//            device port. Optional macro PHY_CSR_HOST_TIMEOUT_EN adds a
//            watchdog that force-completes with an error after
//            TIMEOUT_CYCLES cycles spent in ADDR+RESP.
// Revision : 1.0 - initial release
// ============================================================================
module phy_csr_tl_host
   import tlul_pkg::*;
#(
   parameter int unsigned        TIMEOUT_CYCLES = 1024,
   parameter logic [TL_AIW-1:0]  SRC_INIT       = '0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [TL_AW-1:0]    addr_i,
   input  logic [TL_DW-1:0]    wdata_i,
   input  logic [TL_DBW-1:0]   be_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [TL_DW-1:0]    rdata_o,
   output logic                err_o,
   output logic                busy_o,
   output tl_h2d_t             tl_o,
   input  tl_d2h_t             tl_i
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_ADDR = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   localparam logic [TL_SZW-1:0] c_SIZE = TL_SZW'($clog2(TL_DBW));

   logic [1:0]          r_state;
   logic                r_we;
   logic [TL_AW-1:0]    r_addr;
   logic [TL_DW-1:0]    r_wdata;
   logic [TL_DBW-1:0]   r_be;
   logic [TL_AIW-1:0]   r_src;
   logic [TL_AIW-1:0]   r_tag;
   logic [TL_DW-1:0]    r_rdata;
   logic                r_err;

   logic                w_aligned;
   logic                w_a_hs;
   logic                w_d_hs;
   logic                w_rsp_err;
   logic                w_tmo;

   assign w_aligned = (addr_i[1:0] == 2'b00);
   assign w_a_hs    = (r_state == c_ADDR) && tl_i.a_ready;
   assign w_d_hs    = (r_state == c_RESP) && tl_i.d_valid;

   // A response is bad if flagged by the device, tagged for someone else,
   // or of the wrong class for the request (data for reads, plain ack for writes).
   assign w_rsp_err = tl_i.d_error
                    | (tl_i.d_source != r_tag)
                    | (r_we ? (tl_i.d_opcode != AccessAck) : (tl_i.d_opcode != AccessAckData));

`ifdef PHY_CSR_HOST_TIMEOUT_EN
   logic [15:0] r_tmo_cnt;

   assign w_tmo = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   // Watchdog: cleared while idle, counts every cycle spent waiting in ADDR/RESP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tmo_cnt <= 16'd0;
      end else if (r_state == c_IDLE) begin
         r_tmo_cnt <= 16'd0;
      end else if ((r_state == c_ADDR) || (r_state == c_RESP)) begin
         r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
   end
`else
   localparam int unsigned c_unused_timeout = TIMEOUT_CYCLES;
   assign w_tmo = 1'b0;
`endif

   // Main access FSM: latch request, drive A, wait for D, present one-cycle completion.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= c_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_src   <= SRC_INIT;
         r_tag   <= SRC_INIT;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (req_i) begin
                  r_we    <= we_i;
                  r_addr  <= addr_i;
                  r_wdata <= wdata_i;
                  r_be    <= be_i;
                  if (w_aligned) begin
                     r_state <= c_ADDR;
                  end else begin
                     // Misaligned: refuse without touching the bus.
                     r_err   <= 1'b1;
                     r_state <= c_DONE;
                  end
               end
            end
            c_ADDR: begin
               if (w_a_hs) begin
                  r_tag   <= r_src;
                  r_src   <= r_src + TL_AIW'(1);
                  r_state <= c_RESP;
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_state <= c_DONE;
               end
            end
            c_RESP: begin
               if (w_d_hs) begin
                  if (!r_we) begin
                     r_rdata <= tl_i.d_data;
                  end
                  r_err   <= w_rsp_err;
                  r_state <= c_DONE;
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_state <= c_DONE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // A channel is driven from the latched request so fields stay stable under back-pressure.
   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = (r_state == c_ADDR);
      tl_o.a_opcode  = r_we ? ((&r_be) ? PutFullData : PutPartialData) : Get;
      tl_o.a_param   = 3'd0;
      tl_o.a_size    = c_SIZE;
      tl_o.a_source  = r_src;
      tl_o.a_address = r_addr;
      tl_o.a_mask    = r_we ? r_be : {TL_DBW{1'b1}};
      tl_o.a_data    = r_wdata;
      tl_o.a_user    = TL_A_USER_DEFAULT;
      tl_o.d_ready   = 1'b1;
   end

   assign gnt_o    = ((r_state == c_IDLE) && req_i && !w_aligned) || w_a_hs;
   assign rvalid_o = (r_state == c_DONE);
   assign rdata_o  = r_rdata;
   assign err_o    = r_err;
   assign busy_o   = (r_state != c_IDLE);

   logic unused_tl;
   assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

endmodule
`default_nettype wire

// File: tb/tb_phy_csr_tl_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_csr_tl_host
// Brief    : Self-checking bench for phy_csr_tl_host with a behavioural
//            TL-UL device, A-channel and completion scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_csr_tl_host;
   import tlul_pkg::*;

   logic                clk = 1'b0;
   logic                rst_ni;
   logic                req_i;
   logic                we_i;
   logic [TL_AW-1:0]    addr_i;
   logic [TL_DW-1:0]    wdata_i;
   logic [TL_DBW-1:0]   be_i;
   logic                gnt_o;
   logic                rvalid_o;
   logic [TL_DW-1:0]    rdata_o;
   logic                err_o;
   logic                busy_o;
   tl_h2d_t             tl_o;
   tl_d2h_t             tl_i;

   always #5 clk = ~clk;

   phy_csr_tl_host #(
      .TIMEOUT_CYCLES (8),
      .SRC_INIT       (8'h00)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .we_i     (we_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .be_i     (be_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .busy_o   (busy_o),
      .tl_o     (tl_o),
      .tl_i     (tl_i)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          mode;     // 0 ok, 1 d_error, 2 bad source, 3 bad opcode, 4 no response
      logic [31:0] rsp;
      logic [2:0]  op;
      logic [3:0]  mask;
      logic        err;
      logic [31:0] rdata;
      int          gnt_c;
      int          lat;
   } vec_t;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  src;
   } acc_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } cpl_t;

   acc_t        a_q[$];
   cpl_t        cpl_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          slv_stall = 0;
   int          slv_mode = 0;
   logic [31:0] slv_rdata = '0;
   int          stale_req = 0;
   logic [7:0]  exp_src = 8'h00;
   vec_t        vecs[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_busy"},    busy_o,       1'b0);
      chk({nm, "_gnt"},     gnt_o,        1'b0);
      chk({nm, "_rvalid"},  rvalid_o,     1'b0);
      chk({nm, "_err"},     err_o,        1'b0);
      chk({nm, "_rdata"},   rdata_o,      32'h0);
      chk({nm, "_a_valid"}, tl_o.a_valid, 1'b0);
      chk({nm, "_d_ready"}, tl_o.d_ready, 1'b1);
   endtask

   // Behavioural device: checks every A beat against the expected queue,
   // stalls a_ready on request, answers one cycle after the handshake.
   initial begin : slave
      logic       hs;
      logic       stalled;
      logic [7:0] src;
      logic       is_get;
      int         wait_cnt;
      int         stale_done;
      wait_cnt   = 0;
      stale_done = 0;
      tl_i         = '0;
      tl_i.a_ready = 1'b1;
      forever begin
         @(negedge clk);
         hs      = rst_ni && tl_o.a_valid && tl_i.a_ready;
         stalled = rst_ni && tl_o.a_valid && !tl_i.a_ready;
         src     = tl_o.a_source;
         is_get  = (tl_o.a_opcode == Get);
         if (rst_ni && tl_o.a_valid) begin
            if (a_q.size() == 0) begin
               chk("a_valid_unexpected", tl_o.a_valid, 1'b0);
            end else begin
               chk("a_opcode",  tl_o.a_opcode,  a_q[0].op);
               chk("a_mask",    tl_o.a_mask,    a_q[0].mask);
               chk("a_address", tl_o.a_address, a_q[0].addr);
               chk("a_data",    tl_o.a_data,    a_q[0].data);
               chk("a_source",  tl_o.a_source,  a_q[0].src);
               chk("a_size",    tl_o.a_size,    2'd2);
               chk("a_param",   tl_o.a_param,   3'd0);
               chk("a_user",    tl_o.a_user,    16'h0);
               chk("gnt_vs_handshake", gnt_o, hs);
               if (hs) void'(a_q.pop_front());
            end
         end
         @(posedge clk);
         #1;
         if (hs && slv_mode != 4) begin
            tl_i.d_valid  = 1'b1;
            tl_i.d_opcode = (is_get ^ (slv_mode == 3)) ? AccessAckData : AccessAck;
            tl_i.d_source = (slv_mode == 2) ? ~src : src;
            tl_i.d_error  = (slv_mode == 1);
            tl_i.d_data   = slv_rdata;
         end else if (stale_req != stale_done) begin
            stale_done++;
            tl_i.d_valid  = 1'b1;
            tl_i.d_opcode = AccessAckData;
            tl_i.d_source = 8'hEE;
            tl_i.d_error  = 1'b0;
            tl_i.d_data   = 32'hBAD0_BAD0;
         end else begin
            tl_i.d_valid  = 1'b0;
         end
         if (hs) wait_cnt = 0;
         else if (stalled) wait_cnt++;
         tl_i.a_ready = (wait_cnt >= slv_stall);
      end
   end

   // Completion scoreboard.
   initial begin : monitor
      cpl_t e;
      forever begin
         @(negedge clk);
         if (rst_ni && rvalid_o) begin
            if (cpl_q.size() == 0) begin
               chk("rvalid_unexpected", rvalid_o, 1'b0);
            end else begin
               e = cpl_q.pop_front();
               chk("rdata", rdata_o, e.rdata);
               chk("err",   err_o,   e.err);
            end
         end
      end
   end

   task automatic do_access(input vec_t v, input string nm);
      int   lat;
      int   gcyc;
      logic got_g;
      logic got_v;
      slv_mode  = v.mode;
      slv_rdata = v.rsp;
      if (v.addr[1:0] == 2'b00) begin
         a_q.push_back('{v.op, v.mask, v.addr, v.wdata, exp_src});
         exp_src++;
      end
      cpl_q.push_back('{v.rdata, v.err});
      @(posedge clk);
      #1;
      req_i   = 1'b1;
      we_i    = v.we;
      addr_i  = v.addr;
      wdata_i = v.wdata;
      be_i    = v.be;
      got_g = 1'b0;
      got_v = 1'b0;
      lat   = -1;
      gcyc  = -1;
      for (int c = 0; c < 60 && !got_v; c++) begin
         @(negedge clk);
         if (gnt_o && !got_g) begin
            got_g = 1'b1;
            gcyc  = c;
         end
         if (rvalid_o) begin
            got_v = 1'b1;
            lat   = c;
         end
         @(posedge clk);
         #1;
         if (got_g) req_i = 1'b0;
      end
      req_i = 1'b0;
      chk({nm, "_gnt_cycle"}, gcyc, v.gnt_c);
      chk({nm, "_latency"},   lat,  v.lat);
      chk({nm, "_busy_after"}, busy_o, 1'b0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t v;
      vecs[0]  = '{1'b0, 32'h04, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 3'h4, 4'hF, 1'b0, 32'hDEAD_BEEF, 1, 3};
      vecs[1]  = '{1'b1, 32'h08, 32'h1234_5678, 4'hF, 0, 32'h0,         3'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1, 3};
      vecs[2]  = '{1'b1, 32'h08, 32'h1234_5678, 4'h3, 0, 32'h0,         3'h1, 4'h3, 1'b0, 32'hDEAD_BEEF, 1, 3};
      vecs[3]  = '{1'b1, 32'h0C, 32'hAAAA_5555, 4'h0, 0, 32'h0,         3'h1, 4'h0, 1'b0, 32'hDEAD_BEEF, 1, 3};
      vecs[4]  = '{1'b0, 32'h10, 32'h0,         4'h0, 1, 32'h0BAD_F00D, 3'h4, 4'hF, 1'b1, 32'h0BAD_F00D, 1, 3};
      vecs[5]  = '{1'b0, 32'h14, 32'h0,         4'h0, 2, 32'h1111_2222, 3'h4, 4'hF, 1'b1, 32'h1111_2222, 1, 3};
      vecs[6]  = '{1'b1, 32'h18, 32'hFFFF_0000, 4'hF, 2, 32'h0,         3'h0, 4'hF, 1'b1, 32'h1111_2222, 1, 3};
      vecs[7]  = '{1'b0, 32'h1C, 32'h0,         4'h0, 3, 32'h3333_4444, 3'h4, 4'hF, 1'b1, 32'h3333_4444, 1, 3};
      vecs[8]  = '{1'b1, 32'h20, 32'h0F0F_0F0F, 4'h5, 3, 32'h0,         3'h1, 4'h5, 1'b1, 32'h3333_4444, 1, 3};
      vecs[9]  = '{1'b0, 32'h06, 32'h0,         4'h0, 0, 32'h0,         3'h4, 4'hF, 1'b1, 32'h3333_4444, 0, 1};
      vecs[10] = '{1'b1, 32'h21, 32'h0,         4'hF, 0, 32'h0,         3'h0, 4'hF, 1'b1, 32'h3333_4444, 0, 1};
      vecs[11] = '{1'b0, 32'h24, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 3'h4, 4'hF, 1'b0, 32'hCAFE_F00D, 1, 3};

      rst_ni  = 1'b0;
      req_i   = 1'b0;
      we_i    = 1'b0;
      addr_i  = '0;
      wdata_i = '0;
      be_i    = '0;
      #2;
      chk_reset("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;

      for (int i = 0; i < 12; i++) begin
         do_access(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-pressure: a_ready low for 5 cycles, fields held, gnt only on handshake.
      slv_stall = 5;
      v = '{1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h5A5A_5A5A, 3'h4, 4'hF, 1'b0, 32'h5A5A_5A5A, 6, 8};
      do_access(v, "stall5");
      slv_stall = 0;

      // Stale response while idle must not complete anything.
      stale_req++;
      repeat (4) @(posedge clk);
      #1;
      chk("stale_idle_busy", busy_o, 1'b0);

      // Stale response while stalled in ADDR is discarded; real response completes.
      slv_stall = 3;
      v = '{1'b0, 32'h34, 32'h0, 4'h0, 0, 32'h7777_8888, 3'h4, 4'hF, 1'b0, 32'h7777_8888, 4, 6};
      fork
         do_access(v, "stale_addr");
         begin
            repeat (2) @(posedge clk);
            stale_req++;
         end
      join
      slv_stall = 0;

`ifdef PHY_CSR_HOST_TIMEOUT_EN
      v = '{1'b0, 32'h50, 32'h0, 4'h0, 4, 32'h0, 3'h4, 4'hF, 1'b1, 32'h7777_8888, 1, 9};
      do_access(v, "timeout");
      slv_mode = 0;
      stale_req++;
      repeat (4) @(posedge clk);
      #1;
      chk("timeout_late_busy", busy_o, 1'b0);
`endif

      // Reset in the middle of a stalled access; dropping req_i must not abort first.
      slv_stall = 10;
      a_q.push_back('{3'h4, 4'hF, 32'h40, 32'h0, exp_src});
      @(posedge clk);
      #1;
      req_i   = 1'b1;
      we_i    = 1'b0;
      addr_i  = 32'h40;
      wdata_i = 32'h0;
      be_i    = 4'h0;
      @(posedge clk);
      #1;
      req_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_busy",    busy_o,       1'b1);
      chk("abort_a_valid", tl_o.a_valid, 1'b1);
      rst_ni = 1'b0;
      #1;
      chk_reset("midrst");
      a_q.delete();
      slv_stall = 0;
      exp_src   = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;

      v = '{1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h600D_CAFE, 3'h4, 4'hF, 1'b0, 32'h600D_CAFE, 1, 3};
      do_access(v, "after_rst");

      repeat (3) @(posedge clk);
      #1;
      chk("cpl_q_drained", cpl_q.size(), 0);
      chk("a_q_drained",   a_q.size(),   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
